// File: rtl/hazard_pipe_regs_pkg.sv
// Shared definitions for the pipeline hazard blocks: widths, NOP encoding, Tnew codes.
package hazard_pipe_regs_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned TNEW_W = 2;

  // An all-zero instruction word decodes as a nop.
  localparam logic [DATA_W-1:0] NOP_INSTR = '0;

  // Cycles after E-entry until the result can be forwarded.
  typedef enum logic [TNEW_W-1:0] {
    T_NONE = 2'd0,
    T_ALU  = 2'd1,
    T_LOAD = 2'd2
  } tnew_e;

endpackage

// File: rtl/tnew_stage_reg.sv
// One stage of hazard metadata (WA, RegWr, Tnew) with optional bubble clear and
// optional saturating Tnew decrement.
module tnew_stage_reg
  import hazard_pipe_regs_pkg::*;
#(
  parameter int unsigned AW        = REG_AW,
  parameter int unsigned TW        = TNEW_W,
  parameter bit          Decrement = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic [AW-1:0] wa_i,
  input  logic          regwr_i,
  input  logic [TW-1:0] tnew_i,
  output logic [AW-1:0] wa_o,
  output logic          regwr_o,
  output logic [TW-1:0] tnew_o
);

  logic [AW-1:0] wa_d, wa_q;
  logic          regwr_d, regwr_q;
  logic [TW-1:0] tnew_d, tnew_q;

  // Next state: bubble on clear, otherwise pass through with optional ageing.
  always_comb begin
    wa_d    = wa_i;
    regwr_d = regwr_i;
    tnew_d  = tnew_i;
    if (clear_i) begin
      wa_d    = '0;
      regwr_d = 1'b0;
      tnew_d  = '0;
    end else if (Decrement && (tnew_i != '0)) begin
      tnew_d = tnew_i - TW'(1);
    end
  end

  // Stage register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wa_q    <= '0;
      regwr_q <= 1'b0;
      tnew_q  <= '0;
    end else begin
      wa_q    <= wa_d;
      regwr_q <= regwr_d;
      tnew_q  <= tnew_d;
    end
  end

  assign wa_o    = wa_q;
  assign regwr_o = regwr_q;
  assign tnew_o  = tnew_q;

endmodule

// File: rtl/hazard_pipe_regs.sv
// D->E, E->M and M->W pipeline registers with stall bubble injection, hazard
// metadata tracking and a saturating stall-cycle counter.
module hazard_pipe_regs
  import hazard_pipe_regs_pkg::*;
#(
  parameter int unsigned DW    = DATA_W,
  parameter int unsigned AW    = REG_AW,
  parameter int unsigned TW    = TNEW_W,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stop,
  input  logic [DW-1:0]    instr_D,
  input  logic [DW-1:0]    pc_D,
  input  logic [DW-1:0]    rd1_D,
  input  logic [DW-1:0]    rd2_D,
  input  logic [DW-1:0]    ext_D,
  input  logic [AW-1:0]    WA_D,
  input  logic             RegWr_D,
  input  logic [TW-1:0]    Tnew_D,
  output logic             en_pc,
  output logic             en_fd,
  output logic [DW-1:0]    instr_E,
  output logic [DW-1:0]    pc_E,
  output logic [DW-1:0]    rd1_E,
  output logic [DW-1:0]    rd2_E,
  output logic [DW-1:0]    ext_E,
  output logic [AW-1:0]    WA_E,
  output logic             RegWr_E,
  output logic [TW-1:0]    Tnew_E,
  output logic [DW-1:0]    instr_M,
  output logic [DW-1:0]    pc_M,
  output logic [AW-1:0]    WA_M,
  output logic             RegWr_M,
  output logic [TW-1:0]    Tnew_M,
  output logic [AW-1:0]    WA_W,
  output logic             RegWr_W,
  output logic [TW-1:0]    Tnew_W,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [DW-1:0]    instr_e_d, instr_e_q, pc_e_d, pc_e_q;
  logic [DW-1:0]    rd1_e_d, rd1_e_q, rd2_e_d, rd2_e_q, ext_e_d, ext_e_q;
  logic [DW-1:0]    instr_m_q, pc_m_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic             regwr_d_ok;
  logic [AW-1:0]    wa_d_ok;

  // Freeze PC and IF/ID on stall; held open while reset is asserted.
  assign en_pc = ~(stop & reset);
  assign en_fd = ~(stop & reset);

  // Writes to $0 are dropped here so downstream hazard logic never sees them.
  always_comb begin
    regwr_d_ok = RegWr_D & (WA_D != '0);
    wa_d_ok    = regwr_d_ok ? WA_D : '0;
  end

  // D->E datapath next state: bubble on stall, else capture D.
  always_comb begin
    instr_e_d = instr_D;
    pc_e_d    = pc_D;
    rd1_e_d   = rd1_D;
    rd2_e_d   = rd2_D;
    ext_e_d   = ext_D;
    if (stop) begin
      instr_e_d = DW'(NOP_INSTR);
      pc_e_d    = '0;
      rd1_e_d   = '0;
      rd2_e_d   = '0;
      ext_e_d   = '0;
    end
  end

  // Stall counter next state, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stop && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Datapath registers and stall counter; E->M always advances.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_e_q   <= '0;
      pc_e_q      <= '0;
      rd1_e_q     <= '0;
      rd2_e_q     <= '0;
      ext_e_q     <= '0;
      instr_m_q   <= '0;
      pc_m_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      instr_e_q   <= instr_e_d;
      pc_e_q      <= pc_e_d;
      rd1_e_q     <= rd1_e_d;
      rd2_e_q     <= rd2_e_d;
      ext_e_q     <= ext_e_d;
      instr_m_q   <= instr_e_q;
      pc_m_q      <= pc_e_q;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign instr_E   = instr_e_q;
  assign pc_E      = pc_e_q;
  assign rd1_E     = rd1_e_q;
  assign rd2_E     = rd2_e_q;
  assign ext_E     = ext_e_q;
  assign instr_M   = instr_m_q;
  assign pc_M      = pc_m_q;
  assign stall_cnt = stall_cnt_q;

  tnew_stage_reg #(.AW(AW), .TW(TW), .Decrement(1'b0)) u_meta_e (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clear_i (stop),
    .wa_i    (wa_d_ok),
    .regwr_i (regwr_d_ok),
    .tnew_i  (Tnew_D),
    .wa_o    (WA_E),
    .regwr_o (RegWr_E),
    .tnew_o  (Tnew_E)
  );

  tnew_stage_reg #(.AW(AW), .TW(TW), .Decrement(1'b1)) u_meta_m (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clear_i (1'b0),
    .wa_i    (WA_E),
    .regwr_i (RegWr_E),
    .tnew_i  (Tnew_E),
    .wa_o    (WA_M),
    .regwr_o (RegWr_M),
    .tnew_o  (Tnew_M)
  );

  tnew_stage_reg #(.AW(AW), .TW(TW), .Decrement(1'b1)) u_meta_w (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clear_i (1'b0),
    .wa_i    (WA_M),
    .regwr_i (RegWr_M),
    .tnew_i  (Tnew_M),
    .wa_o    (WA_W),
    .regwr_o (RegWr_W),
    .tnew_o  (Tnew_W)
  );

endmodule
